// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} lsu_state_e;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  // Bit offset of byte lane i within a data_w-bit word.
  function automatic int unsigned lane_lsb(input int unsigned i, input int unsigned data_w,
                                           input bit big_endian);
    return big_endian ? (data_w - 8 - 8 * i) : (8 * i);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: extracts lane idx of a word for stores and decodes the
// matching one-hot lane write enable for load assembly.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned IDX_W      = 1
) (
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DATA_W-1:0]   word_i,
  output logic [7:0]          byte_o,
  output logic [DATA_W/8-1:0] lane_en_o
);

  localparam int unsigned NB = DATA_W / 8;

  always_comb begin
    byte_o    = '0;
    lane_en_o = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (idx_i == IDX_W'(k)) begin
        byte_o       = word_i[lane_lsb(k, DATA_W, BIG_ENDIAN) +: 8];
        lane_en_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store engine: moves one DATA_W-bit word to or from a
// byte-wide memory, one byte lane per transfer step.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Op,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_CS,
  input  logic [7:0]        Mem_RData
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;

  lsu_state_e        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        wait_q, wait_d;

  logic [7:0]    lane_byte;
  logic [NB-1:0] lane_en;
  logic          last_byte;

  assign last_byte = (idx_q == IdxW'(NB - 1));

  lsu_byte_lane #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN),
    .IDX_W      (IdxW)
  ) u_byte_lane (
    .idx_i     (idx_q),
    .word_i    (wdata_q),
    .byte_o    (lane_byte),
    .lane_en_o (lane_en)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          op_d    = Op;
          addr_d  = Addr;
          wdata_d = WData;
          idx_d   = '0;
          wait_d  = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (op_q == OP_STORE) begin
          if (last_byte) state_d = StDone;
          else           idx_d   = idx_q + IdxW'(1);
        end else if (wait_q == 2'(MEM_LAT)) begin
          for (int unsigned k = 0; k < NB; k++) begin
            if (lane_en[k]) asm_d[lane_lsb(k, DATA_W, BIG_ENDIAN) +: 8] = Mem_RData;
          end
          wait_d = '0;
          // The final byte goes straight into RData so it is visible during DONE.
          if (last_byte) begin
            rdata_d = asm_d;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  // Memory-side outputs depend on registered state only.
  always_comb begin
    Busy        = (state_q != StIdle);
    Done        = (state_q == StDone);
    RData       = rdata_q;
    Mem_CS      = (state_q != StXfer);
    Mem_WR      = (state_q == StXfer) && (op_q == OP_STORE);
    Mem_Address = (state_q == StXfer) ? (addr_q + ADDR_W'(idx_q)) : '0;
    Mem_Data    = Mem_WR ? lane_byte : 8'h00;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised self-checking bench: three LSU configurations against a
// behavioural byte memory with latency-aware read data.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [3];
  logic        op_v    [3];
  logic [15:0] addr_v  [3];
  logic [63:0] wdata_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] maddr_v [3];
  logic [7:0]  mdata_v [3];
  logic        mwr_v   [3];
  logic        mcs_v   [3];
  logic [7:0]  mrd_v   [3];
  logic [15:0] rdata0;
  logic [31:0] rdata1, rdata2;

  load_store_unit #(.DATA_W(16), .ADDR_W(16), .BIG_ENDIAN(1'b0), .MEM_LAT(1)) u_dut0 (
    .Clock(clk), .Reset(rst_n), .Start(start_v[0]), .Op(op_v[0]), .Addr(addr_v[0]),
    .WData(wdata_v[0][15:0]), .Busy(busy_v[0]), .Done(done_v[0]), .RData(rdata0),
    .Mem_Address(maddr_v[0]), .Mem_Data(mdata_v[0]), .Mem_WR(mwr_v[0]), .Mem_CS(mcs_v[0]),
    .Mem_RData(mrd_v[0]));

  load_store_unit #(.DATA_W(32), .ADDR_W(16), .BIG_ENDIAN(1'b1), .MEM_LAT(0)) u_dut1 (
    .Clock(clk), .Reset(rst_n), .Start(start_v[1]), .Op(op_v[1]), .Addr(addr_v[1]),
    .WData(wdata_v[1][31:0]), .Busy(busy_v[1]), .Done(done_v[1]), .RData(rdata1),
    .Mem_Address(maddr_v[1]), .Mem_Data(mdata_v[1]), .Mem_WR(mwr_v[1]), .Mem_CS(mcs_v[1]),
    .Mem_RData(mrd_v[1]));

  load_store_unit #(.DATA_W(32), .ADDR_W(16), .BIG_ENDIAN(1'b0), .MEM_LAT(2)) u_dut2 (
    .Clock(clk), .Reset(rst_n), .Start(start_v[2]), .Op(op_v[2]), .Addr(addr_v[2]),
    .WData(wdata_v[2][31:0]), .Busy(busy_v[2]), .Done(done_v[2]), .RData(rdata2),
    .Mem_Address(maddr_v[2]), .Mem_Data(mdata_v[2]), .Mem_WR(mwr_v[2]), .Mem_CS(mcs_v[2]),
    .Mem_RData(mrd_v[2]));

  function automatic int nb_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction
  function automatic bit be_of(input int k);
    return (k == 1);
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
  endfunction
  function automatic logic [63:0] get_rdata(input int k);
    if (k == 0)      return {48'h0, rdata0};
    else if (k == 1) return {32'h0, rdata1};
    else             return {32'h0, rdata2};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural memory: read data is only correct once the address has been
  // held for MEM_LAT earlier cycles; before that it returns the inverted byte.
  logic [7:0]  mem [3][65536];
  bit          trk [3];
  logic [15:0] hold_addr [3];
  int          hold_cnt [3];
  int          wr_cnt [3];
  int          done_cnt [3];
  logic [63:0] last_rdata [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k]) done_cnt[k]++;
      if (!mcs_v[k]) begin
        if (trk[k] && maddr_v[k] == hold_addr[k]) hold_cnt[k]++;
        else begin
          hold_addr[k] = maddr_v[k];
          hold_cnt[k]  = 0;
          trk[k]       = 1'b1;
        end
        mrd_v[k] = (hold_cnt[k] >= lat_of(k)) ? mem[k][maddr_v[k]] : ~mem[k][maddr_v[k]];
        if (mwr_v[k]) begin
          mem[k][maddr_v[k]] = mdata_v[k];
          wr_cnt[k]++;
        end
      end else begin
        trk[k]   = 1'b0;
        mrd_v[k] = 8'h00;
      end
    end
  end

  task automatic run_xfer(input int k, input logic op, input logic [15:0] a,
                          input logic [63:0] wd, input bit poke);
    int          nb, cyc, busy_cyc, exp_cyc, wr0, d0;
    logic [63:0] mask, exp_word, wdm, sh;
    logic [15:0] ba;
    logic [7:0]  exp_b;
    nb   = nb_of(k);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    wdm  = wd & mask;
    exp_word = last_rdata[k];
    if (op == 1'b0) begin
      exp_word = '0;
      for (int j = 0; j < nb; j++) begin
        ba = a + 16'(j);
        sh = {56'h0, mem[k][ba]};
        exp_word |= be_of(k) ? (sh << (8 * (nb - 1 - j))) : (sh << (8 * j));
      end
    end
    wr0 = wr_cnt[k];
    d0  = done_cnt[k];
    @(negedge clk);
    start_v[k] = 1'b1; op_v[k] = op; addr_v[k] = a; wdata_v[k] = wdm;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    cyc = 1; busy_cyc = 0;
    while (!done_v[k] && cyc < 200) begin
      if (busy_v[k]) busy_cyc++;
      if (poke) start_v[k] = (cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    if (busy_v[k]) busy_cyc++;
    exp_cyc = nb * (op ? 1 : lat_of(k) + 1) + 1;
    check_eq("done_seen", {63'h0, done_v[k]}, 64'd1);
    check_eq("done_latency", 64'(cyc), 64'(exp_cyc));
    check_eq("busy_cycles", 64'(busy_cyc), 64'(exp_cyc));
    check_eq("rdata_in_done", get_rdata(k), exp_word);
    if (poke) start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    check_eq("idle_busy", {63'h0, busy_v[k]}, 64'd0);
    check_eq("idle_cs", {63'h0, mcs_v[k]}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_retrigger", {63'h0, busy_v[k]}, 64'd0);
    check_eq("done_pulses", 64'(done_cnt[k] - d0), 64'd1);
    check_eq("write_count", 64'(wr_cnt[k] - wr0), op ? 64'(nb) : 64'd0);
    if (op == 1'b1) begin
      for (int j = 0; j < nb; j++) begin
        ba    = a + 16'(j);
        sh    = be_of(k) ? (wdm >> (8 * (nb - 1 - j))) : (wdm >> (8 * j));
        exp_b = sh[7:0];
        check_eq("store_byte", {56'h0, mem[k][ba]}, {56'h0, exp_b});
      end
    end
    last_rdata[k] = exp_word;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [63:0] rd;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 0; op_v[k] = 0; addr_v[k] = 0; wdata_v[k] = 0; mrd_v[k] = 0;
      trk[k] = 0; hold_addr[k] = 0; hold_cnt[k] = 0; wr_cnt[k] = 0; done_cnt[k] = 0;
      last_rdata[k] = 0;
      for (int a = 0; a < 65536; a++) mem[k][a] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_busy", {63'h0, busy_v[k]}, 64'd0);
      check_eq("rst_done", {63'h0, done_v[k]}, 64'd0);
      check_eq("rst_rdata", get_rdata(k), 64'd0);
      check_eq("rst_addr", {48'h0, maddr_v[k]}, 64'd0);
      check_eq("rst_mdata", {56'h0, mdata_v[k]}, 64'd0);
      check_eq("rst_wr", {63'h0, mwr_v[k]}, 64'd0);
      check_eq("rst_cs", {63'h0, mcs_v[k]}, 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    run_xfer(0, 1'b1, 16'h0010, 64'hA55A, 0);
    check_eq("a55a_lo", {56'h0, mem[0][16'h0010]}, 64'h5A);
    check_eq("a55a_hi", {56'h0, mem[0][16'h0011]}, 64'hA5);
    mem[0][16'h0010] = 8'h34;
    mem[0][16'h0011] = 8'h12;
    run_xfer(0, 1'b0, 16'h0010, 64'h0, 0);
    check_eq("load_1234", get_rdata(0), 64'h1234);
    mem[1][16'h0100] = 8'hDE; mem[1][16'h0101] = 8'hAD;
    mem[1][16'h0102] = 8'hBE; mem[1][16'h0103] = 8'hEF;
    run_xfer(1, 1'b0, 16'h0100, 64'h0, 0);
    check_eq("load_deadbeef", get_rdata(1), 64'hDEADBEEF);
    run_xfer(2, 1'b1, 16'hFFFE, 64'h11223344, 0);
    check_eq("wrap_fffe", {56'h0, mem[2][16'hFFFE]}, 64'h44);
    check_eq("wrap_ffff", {56'h0, mem[2][16'hFFFF]}, 64'h33);
    check_eq("wrap_0000", {56'h0, mem[2][16'h0000]}, 64'h22);
    check_eq("wrap_0001", {56'h0, mem[2][16'h0001]}, 64'h11);
    run_xfer(0, 1'b1, 16'h0400, 64'h1357, 1);
    run_xfer(1, 1'b0, 16'h0500, 64'h0, 1);
    run_xfer(2, 1'b0, 16'hFFFF, 64'h0, 1);

    // Randomised transfers, biased towards the top-of-memory wrap.
    for (int n = 0; n < 36; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                       : 16'($urandom);
      rd = {$urandom, $urandom};
      run_xfer(n % 3, 1'($urandom), ra, rd, 1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a store, after its first byte.
    run_xfer(0, 1'b0, 16'h0300, 64'h0, 0);
    mem[0][16'h0200] = 8'h77;
    mem[0][16'h0201] = 8'h66;
    @(negedge clk);
    start_v[0] = 1'b1; op_v[0] = 1'b1; addr_v[0] = 16'h0200; wdata_v[0] = 64'hBEEF;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cs", {63'h0, mcs_v[0]}, 64'd1);
    check_eq("mid_rst_wr", {63'h0, mwr_v[0]}, 64'd0);
    check_eq("mid_rst_busy", {63'h0, busy_v[0]}, 64'd0);
    check_eq("mid_rst_rdata", get_rdata(0), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) last_rdata[k] = '0;
    check_eq("rst_first_byte", {56'h0, mem[0][16'h0200]}, 64'hEF);
    check_eq("rst_second_byte", {56'h0, mem[0][16'h0201]}, 64'h66);
    check_eq("post_rst_rdata", get_rdata(0), 64'd0);
    run_xfer(0, 1'b1, 16'h0200, 64'hBEEF, 0);
    run_xfer(0, 1'b0, 16'h0200, 64'h0, 0);
    check_eq("post_rst_load", get_rdata(0), 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised byte-serial load/store engine for the CPU datapath. It moves one DATA_W-bit word between a register-side port and the byte-wide memory. A load assembles the word from consecutive bytes; a store splits it into consecutive bytes. This generalises the fixed two-byte high/low sequencing of the 16-bit datapath to any multiple-of-8 width, either byte order, and configurable memory read latency. It sits between the ALU/register-file side and the memory, and is driven by the control unit with a start/done handshake.

## Interface
- DATA_W, 16, word width in bits; multiple of 8, range 8..64
- ADDR_W, 16, memory address width
- BIG_ENDIAN, 0, 0: byte 0 at the base address is bits [7:0]; 1: byte 0 is the most significant byte
- MEM_LAT, 1, memory read latency in cycles from address to data valid; range 0..3

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request strobe; sampled only in IDLE
- Op  in  1  0 = load, 1 = store; captured with Start
- Addr  in  ADDR_W  base byte address; captured with Start
- WData  in  DATA_W  store word; captured with Start
- Busy  out  1  high from the cycle after an accepted Start until the end of DONE
- Done  out  1  one-cycle completion pulse
- RData  out  DATA_W  last loaded word; held until the next load completes
- Mem_Address  out  ADDR_W  byte address to memory
- Mem_Data  out  8  store byte to memory
- Mem_WR  out  1  1 = write, 0 = read
- Mem_CS  out  1  active-low chip select
- Mem_RData  in  8  read byte from memory

## Operation
- Derived constant: NB = DATA_W/8 bytes per word.
- States: IDLE, XFER, DONE.
- IDLE:
  - Mem_CS = 1, Mem_WR = 0, Busy = 0.
  - Start = 1 captures Op, Addr and WData, clears byte index i and wait counter w, then goes to XFER.
- XFER:
  - Mem_Address = Addr_q + i, modulo 2^ADDR_W. Wrap past all-ones to 0 is legal.
  - Mem_CS = 0 throughout.
- Store in XFER:
  - Mem_WR = 1 and Mem_Data = the lane-i byte of WData_q, for exactly one cycle per byte.
  - i increments each cycle; after i = NB-1, go to DONE.
- Load in XFER:
  - Mem_WR = 0. The address is held for MEM_LAT+1 cycles while w counts 0..MEM_LAT.
  - When w = MEM_LAT, Mem_RData is written into lane i of the assembly register, w clears and i increments.
  - After the byte at i = NB-1 is captured, go to DONE.
- Lane mapping:
  - BIG_ENDIAN = 0: lane i is bits [8i+7:8i].
  - BIG_ENDIAN = 1: lane i is bits [DATA_W-1-8i : DATA_W-8-8i].
- DONE:
  - Done = 1 and Busy = 1 for one cycle, Mem_CS = 1.
  - For a load, RData takes the assembled word on the clock edge entering DONE, so it is visible during DONE.
  - A store leaves RData unchanged. Next state is IDLE.
- Start while Busy is ignored; there is no queueing and no error flag.
- Start in the same cycle as DONE is ignored. The earliest accepted Start is the first IDLE cycle.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, RData 0, Mem_Address 0, Mem_Data 0, Mem_WR 0, Mem_CS 1. All internal registers reset to 0.
- Reset asserted mid-transfer forces IDLE immediately (asynchronously). Mem_WR and Mem_CS deassert in the same cycle, and no further bytes are written. Bytes already written stay in memory. RData returns to 0.
- Store latency from the Start edge to Done: NB cycles in XFER, then 1 DONE cycle. Total cycles in Busy = NB+1.
- Load latency: NB*(MEM_LAT+1) XFER cycles, then 1 DONE cycle.
- The outputs Mem_Address, Mem_Data, Mem_WR and Mem_CS are decoded from registered state only. Start has no combinational path to memory.
- With MEM_LAT = 0, Mem_RData is sampled in the same cycle its address is presented (combinational memory read).

## Structure
- Shared package lsu_pkg holds:
  - the state enum (IDLE, XFER, DONE)
  - the op constants (OP_LOAD = 0, OP_STORE = 1)
  - a lane-offset function lane_lsb(i, DATA_W, BIG_ENDIAN)
- One natural sub-module: lsu_byte_lane. It is a combinational NB-way byte extract for stores and a byte-lane write-enable decode for loads. Both are driven by i and BIG_ENDIAN.
- The FSM, counters and capture registers live in load_store_unit.

## Test plan
- DATA_W = 16, LE, MEM_LAT = 1; store 16'hA55A at 16'h0010.
  - Bytes 5A at 0010 and A5 at 0011, one cycle each.
  - Done pulses on cycle 3 after Start; Busy is high for 3 cycles.
- Same configuration; memory preloaded 0010 = 34, 0011 = 12; load.
  - RData = 16'h1234 during DONE.
  - Done arrives 5 cycles after Start; each address is held 2 cycles.
- DATA_W = 32, BIG_ENDIAN = 1, MEM_LAT = 0; memory 0100..0103 = DE AD BE EF; load.
  - RData = 32'hDEADBEEF; latency 4+1 cycles.
- DATA_W = 32, LE; store 32'h11223344 at 16'hFFFE.
  - Writes land at FFFE = 44, FFFF = 33, 0000 = 22, 0001 = 11 (wrap-around).
- Start pulsed during XFER, and again in the DONE cycle.
  - Both are ignored: exactly one transfer occurs and only one Done pulse is seen.
- Reset pulled low after the first store byte.
  - Mem_CS goes to 1 and Mem_WR to 0 immediately; only that first byte is in memory.
  - After reset releases: Busy = 0, RData = 0, and a new Start runs a full transfer.
